// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester and RAM-port signals of the video-RAM arbiter
// slave  : arbiter side (takes requests and ram_q, drives results and the RAM port)
// master : requester/RAM side (VDG, CPU, loader, dpram port A)
interface vram_arbiter_if #(parameter int AW = 12, parameter int DW = 8);
  logic          vdg_req;
  logic [AW-1:0] vdg_addr;
  logic [DW-1:0] vdg_data;
  logic          vdg_valid;
  logic          vdg_overrun;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          ldr_wr;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_data;
  logic          ldr_busy;
  logic          ram_we;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;
  modport slave (
    input  vdg_req, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           ldr_wr, ldr_addr, ldr_data, ram_q,
    output vdg_data, vdg_valid, vdg_overrun, cpu_rdata, cpu_ack, ldr_busy,
           ram_we, ram_ad, ram_d
  );
  modport master (
    output vdg_req, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           ldr_wr, ldr_addr, ldr_data, ram_q,
    input  vdg_data, vdg_valid, vdg_overrun, cpu_rdata, cpu_ack, ldr_busy,
           ram_we, ram_ad, ram_d
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: one-access-per-clock video-RAM port sequencer for VDG, loader and CPU
// clk_sys : rising-edge clock
// reset_n : asynchronous active-low reset
// bus     : vram_arbiter_if.slave (VDG fetch, CPU bus, loader writes, dpram port A)
// Priority VDG > loader > CPU, except the CPU wins outright once it has waited STARVE edges.
module vram_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input logic          clk_sys,
  input logic          reset_n,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_VDG, OWN_LDR, OWN_CPU} own_t;
  localparam logic [3:0] STARVE_L = 4'(STARVE);
  logic          vdg_pend, ldr_pend, cpu_infl, s1_rd, cpu_elig;
  logic [AW-1:0] vdg_pa, ldr_pa;
  logic [DW-1:0] ldr_pd;
  logic [3:0]    starve;
  own_t          win, s1_own, s2_own;
  always_comb begin
    cpu_elig = bus.cpu_req & ~cpu_infl;
    win = (cpu_elig && starve >= STARVE_L) ? OWN_CPU :
          vdg_pend ? OWN_VDG :
          ldr_pend ? OWN_LDR :
          cpu_elig ? OWN_CPU : OWN_NONE;
  end
  assign bus.ldr_busy = ldr_pend;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vdg_pend        <= 1'b0;
      vdg_pa          <= '0;
      ldr_pend        <= 1'b0;
      ldr_pa          <= '0;
      ldr_pd          <= '0;
      cpu_infl        <= 1'b0;
      starve          <= '0;
      s1_own          <= OWN_NONE;
      s1_rd           <= 1'b0;
      s2_own          <= OWN_NONE;
      bus.ram_we      <= 1'b0;
      bus.ram_ad      <= '0;
      bus.ram_d       <= '0;
      bus.vdg_valid   <= 1'b0;
      bus.vdg_data    <= '0;
      bus.vdg_overrun <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.cpu_rdata   <= '0;
    end else begin
      // A request arriving on the edge its predecessor is granted simply refills the slot.
      if (bus.vdg_req) begin
        vdg_pend <= 1'b1;
        vdg_pa   <= bus.vdg_addr;
        if (vdg_pend && win != OWN_VDG) bus.vdg_overrun <= 1'b1;
      end else if (win == OWN_VDG) vdg_pend <= 1'b0;
      if (bus.ldr_wr && (!ldr_pend || win == OWN_LDR)) begin
        ldr_pend <= 1'b1;
        ldr_pa   <= bus.ldr_addr;
        ldr_pd   <= bus.ldr_data;
      end else if (win == OWN_LDR) ldr_pend <= 1'b0;
      // In-flight drops on the ack edge, so a still-high cpu_req a cycle later is a new access.
      cpu_infl <= (win == OWN_CPU) | (cpu_infl & ~bus.cpu_ack);
      starve   <= (!bus.cpu_req || win == OWN_CPU) ? 4'd0 :
                  (cpu_elig && starve != 4'hF) ? starve + 4'd1 : starve;
      bus.ram_we <= (win == OWN_LDR) || (win == OWN_CPU && bus.cpu_we);
      bus.ram_ad <= win == OWN_VDG ? vdg_pa : win == OWN_LDR ? ldr_pa :
                    win == OWN_CPU ? bus.cpu_addr : bus.ram_ad;
      bus.ram_d  <= win == OWN_LDR ? ldr_pd : win == OWN_CPU ? bus.cpu_wdata : bus.ram_d;
      s1_own <= win;
      s1_rd  <= (win == OWN_VDG) || (win == OWN_CPU && !bus.cpu_we);
      // Stage 2 only tracks reads: ram_q for a stage-1 read is captured one edge later.
      s2_own <= s1_rd ? s1_own : OWN_NONE;
      bus.vdg_valid <= s2_own == OWN_VDG;
      bus.vdg_data  <= s2_own == OWN_VDG ? bus.ram_q : bus.vdg_data;
      bus.cpu_ack   <= (s2_own == OWN_CPU) || (s1_own == OWN_CPU && !s1_rd);
      bus.cpu_rdata <= s2_own == OWN_CPU ? bus.ram_q : bus.cpu_rdata;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a synchronous RAM model
module tb_vram_arbiter;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] ram [4096];
  logic [7:0] exp_mem [4096];
  logic [7:0] vdg_q [$];
  logic [8:0] cpu_q [$];
  vram_arbiter_if #(.AW(12), .DW(8)) bus ();
  vram_arbiter #(.AW(12), .DW(8), .STARVE(4)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) begin
    if (bus.ram_we) ram[bus.ram_ad] <= bus.ram_d;
    bus.ram_q <= ram[bus.ram_ad];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (bus.vdg_valid) begin
        if (vdg_q.size() == 0) check("vdg_valid_unexp", 1, 0);
        else check("vdg_data", bus.vdg_data, vdg_q.pop_front());
      end
      if (bus.cpu_ack) begin
        if (cpu_q.size() == 0) check("cpu_ack_unexp", 1, 0);
        else begin
          logic [8:0] e;
          e = cpu_q.pop_front();
          if (e[8]) check("cpu_rdata", bus.cpu_rdata, e[7:0]);
        end
      end
    end
  end
  task automatic cyc;
    @(negedge clk_sys);
  endtask
  task automatic idle;
    bus.vdg_req = 0; bus.vdg_addr = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ldr_wr = 0; bus.ldr_addr = 0; bus.ldr_data = 0;
  endtask
  task automatic do_reset;
    check("vdg_q_left", vdg_q.size(), 0);
    check("cpu_q_left", cpu_q.size(), 0);
    idle;
    reset_n = 0;
    repeat (2) cyc;
    reset_n = 1;
    cyc;
  endtask
  task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] d);
    bit got;
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    if (we) exp_mem[a] = d;
    cpu_q.push_back({~we, exp_mem[a]});
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc;
      got = bus.cpu_ack;
    end
    check("cpu_ack_seen", {31'd0, got}, 1);
    bus.cpu_req = 0;
    cyc;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'(i * 7 + 3);
      exp_mem[i] = 8'(i * 7 + 3);
    end
    idle;
    do_reset;
    // reset in the middle of a CPU read
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h005;
    cyc;
    check("t1_ram_ad_grant", bus.ram_ad, 12'h005);
    check("t1_ram_we_grant", bus.ram_we, 0);
    reset_n = 0; bus.cpu_req = 0;
    #1;
    check("t1_rst_ram", {bus.ram_we, bus.ram_ad, bus.ram_d}, 0);
    check("t1_rst_out", {bus.cpu_ack, bus.cpu_rdata, bus.vdg_valid, bus.vdg_data,
                         bus.vdg_overrun, bus.ldr_busy}, 0);
    repeat (2) cyc;
    reset_n = 1;
    cyc;
    check("t1_no_ack", bus.cpu_ack, 0);
    bus.vdg_req = 1; bus.vdg_addr = 12'h123; vdg_q.push_back(exp_mem[12'h123]);
    cyc;
    bus.vdg_req = 0;
    cyc;
    check("t1_vdg_ad", bus.ram_ad, 12'h123);
    cyc;
    check("t1_valid_e1", bus.vdg_valid, 0);
    cyc;
    check("t1_valid_e2", bus.vdg_valid, 1);
    cyc;
    check("t1_valid_e3", bus.vdg_valid, 0);
    // simultaneous pending requests
    do_reset;
    bus.vdg_req = 1; bus.vdg_addr = 12'h010; vdg_q.push_back(exp_mem[12'h010]);
    bus.ldr_wr = 1; bus.ldr_addr = 12'h020; bus.ldr_data = 8'hAA; exp_mem[12'h020] = 8'hAA;
    cyc;
    check("t2_busy", bus.ldr_busy, 1);
    bus.vdg_req = 0; bus.ldr_wr = 0;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h030; bus.cpu_wdata = 8'h55;
    exp_mem[12'h030] = 8'h55; cpu_q.push_back(9'h000);
    cyc;
    check("t2_e0_ad", bus.ram_ad, 12'h010);
    check("t2_e0_we", bus.ram_we, 0);
    cyc;
    check("t2_e1_ad", bus.ram_ad, 12'h020);
    check("t2_e1_wd", {bus.ram_we, bus.ram_d}, 9'h1AA);
    check("t2_e1_busy", bus.ldr_busy, 0);
    cyc;
    check("t2_e2_ad", bus.ram_ad, 12'h030);
    check("t2_e2_wd", {bus.ram_we, bus.ram_d}, 9'h155);
    check("t2_e2_ack", bus.cpu_ack, 0);
    check("t2_e2_vvalid", bus.vdg_valid, 1);
    cyc;
    check("t2_e3_ack", bus.cpu_ack, 1);
    check("t2_e3_we", bus.ram_we, 0);
    bus.cpu_req = 0;
    cyc;
    check("t2_ram20", ram[12'h020], exp_mem[12'h020]);
    check("t2_ram30", ram[12'h030], exp_mem[12'h030]);
    // CPU starvation override
    do_reset;
    for (int k = 0; k < 13; k++) begin
      if (k == 5) begin
        check("t3_ad_e3", bus.ram_ad, 12'h103);
        check("t3_ovr_e3", bus.vdg_overrun, 0);
      end
      if (k == 6) begin
        check("t3_cpu_grant", {bus.ram_we, bus.ram_ad}, 13'h0040);
        check("t3_ovr_e4", bus.vdg_overrun, 1);
      end
      if (k == 7) check("t3_ack_e5", bus.cpu_ack, 0);
      if (k == 8) check("t3_ack_e6", bus.cpu_ack, 1);
      bus.vdg_req = k < 10;
      bus.vdg_addr = 12'(12'h100 + k);
      if (k < 10 && k != 4) vdg_q.push_back(exp_mem[12'h100 + k]);
      if (k == 1) begin
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h040;
        cpu_q.push_back({1'b1, exp_mem[12'h040]});
      end
      if (k == 8) bus.cpu_req = 0;
      cyc;
    end
    repeat (3) cyc;
    check("t3_ovr_end", bus.vdg_overrun, 1);
    // back-to-back VDG reads
    do_reset;
    for (int k = 0; k < 14; k++) begin
      if (k == 3 || k == 12) check("t4_valid_off", bus.vdg_valid, 0);
      if (k >= 4 && k <= 11) check("t4_valid_on", bus.vdg_valid, 1);
      bus.vdg_req = k < 8;
      bus.vdg_addr = 12'(k);
      if (k < 8) vdg_q.push_back(exp_mem[k]);
      cyc;
    end
    check("t4_ovr", bus.vdg_overrun, 0);
    // loader backpressure under VDG saturation
    do_reset;
    for (int k = 0; k < 12; k++) begin
      if (k >= 3 && k <= 7) check("t5_busy_on", bus.ldr_busy, 1);
      if (k == 8) begin
        check("t5_busy_off", bus.ldr_busy, 0);
        check("t5_ldr_grant", {bus.ram_we, bus.ram_ad, bus.ram_d}, {1'b1, 12'h050, 8'h11});
      end
      bus.vdg_req = k < 6;
      bus.vdg_addr = 12'(12'h300 + k);
      if (k < 6) vdg_q.push_back(exp_mem[12'h300 + k]);
      bus.ldr_wr = k == 2 || k == 3;
      bus.ldr_addr = k == 2 ? 12'h050 : 12'h051;
      bus.ldr_data = k == 2 ? 8'h11 : 8'h22;
      if (k == 2) exp_mem[12'h050] = 8'h11;
      cyc;
    end
    check("t5_ram50", ram[12'h050], exp_mem[12'h050]);
    check("t5_ram51", ram[12'h051], exp_mem[12'h051]);
    check("t5_ovr", bus.vdg_overrun, 0);
    // CPU read-after-write
    do_reset;
    cpu_access(1, 12'h200, 8'h7F);
    cpu_access(0, 12'h200, 8'h00);
    cpu_access(0, 12'h020, 8'h00);
    repeat (3) cyc;
    check("vdg_q_end", vdg_q.size(), 0);
    check("cpu_q_end", cpu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
